// File: rtl/arcade_input_pkg.sv
// Shared constants, key-state layout and scancode decoding for the arcade input mapper.
package arcade_input_pkg;

    localparam int KEY_BITS  = 10;
    localparam int KEY_BTN0  = 4;
    localparam int KEY_START = 8;
    localparam int KEY_COIN  = 9;

    localparam logic [7:0] SC_P0_UP    = 8'h75;
    localparam logic [7:0] SC_P0_DOWN  = 8'h72;
    localparam logic [7:0] SC_P0_LEFT  = 8'h6B;
    localparam logic [7:0] SC_P0_RIGHT = 8'h74;
    localparam logic [7:0] SC_P0_B0A   = 8'h14;
    localparam logic [7:0] SC_P0_B0B   = 8'h29;
    localparam logic [7:0] SC_P0_B1    = 8'h11;
    localparam logic [7:0] SC_P0_B2    = 8'h12;
    localparam logic [7:0] SC_P0_B3    = 8'h1A;
    localparam logic [7:0] SC_P0_START = 8'h05;
    localparam logic [7:0] SC_P0_COIN  = 8'h2E;
    localparam logic [7:0] SC_P1_UP    = 8'h2D;
    localparam logic [7:0] SC_P1_DOWN  = 8'h2B;
    localparam logic [7:0] SC_P1_LEFT  = 8'h23;
    localparam logic [7:0] SC_P1_RIGHT = 8'h34;
    localparam logic [7:0] SC_P1_B0    = 8'h1C;
    localparam logic [7:0] SC_P1_B1    = 8'h1B;
    localparam logic [7:0] SC_P1_B2    = 8'h15;
    localparam logic [7:0] SC_P1_B3    = 8'h1D;
    localparam logic [7:0] SC_P1_START = 8'h06;
    localparam logic [7:0] SC_P1_COIN  = 8'h36;

    typedef enum logic [1:0] {
        ROT_NONE = 2'd0,
        ROT_CW   = 2'd1,
        ROT_FLIP = 2'd2,
        ROT_CCW  = 2'd3
    } rotate_e;

    typedef logic [KEY_BITS-1:0] key_state_t;

    typedef struct packed {
        logic       hit;
        logic       player;
        logic [3:0] idx;
    } key_map_t;

    function automatic int joy_btn_idx(input int k);
        return 4 + k;
    endfunction

    function automatic int joy_start_idx(input int nbuttons);
        return 4 + nbuttons;
    endfunction

    function automatic int joy_coin_idx(input int nbuttons);
        return 5 + nbuttons;
    endfunction

    // Key-state slot uses the joystick bit order: [0]R [1]L [2]D [3]U, [4+k] button, [8] start, [9] coin.
    function automatic key_map_t map_key(input logic ext, input logic [7:0] code);
        key_map_t m;
        m = '{hit: 1'b1, player: 1'b0, idx: 4'd0};
        case (code)
            SC_P0_UP:              begin m.idx = 4'd3; m.hit = ext; end
            SC_P0_DOWN:            begin m.idx = 4'd2; m.hit = ext; end
            SC_P0_LEFT:            begin m.idx = 4'd1; m.hit = ext; end
            SC_P0_RIGHT:           begin m.idx = 4'd0; m.hit = ext; end
            SC_P0_B0A, SC_P0_B0B:  m.idx = 4'd4;
            SC_P0_B1:              m.idx = 4'd5;
            SC_P0_B2:              m.idx = 4'd6;
            SC_P0_B3:              m.idx = 4'd7;
            SC_P0_START:           m.idx = 4'd8;
            SC_P0_COIN:            m.idx = 4'd9;
            SC_P1_UP:              begin m.player = 1'b1; m.idx = 4'd3; end
            SC_P1_DOWN:            begin m.player = 1'b1; m.idx = 4'd2; end
            SC_P1_LEFT:            begin m.player = 1'b1; m.idx = 4'd1; end
            SC_P1_RIGHT:           begin m.player = 1'b1; m.idx = 4'd0; end
            SC_P1_B0:              begin m.player = 1'b1; m.idx = 4'd4; end
            SC_P1_B1:              begin m.player = 1'b1; m.idx = 4'd5; end
            SC_P1_B2:              begin m.player = 1'b1; m.idx = 4'd6; end
            SC_P1_B3:              begin m.player = 1'b1; m.idx = 4'd7; end
            SC_P1_START:           begin m.player = 1'b1; m.idx = 4'd8; end
            SC_P1_COIN:            begin m.player = 1'b1; m.idx = 4'd9; end
            default:               m.hit = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/arcade_input_mapper_if.sv
// Player-facing bus of the input mapper: raw key/joystick inputs and mapped player outputs.
interface arcade_input_mapper_if #(
    parameter int NPLAYERS = 2,
    parameter int NBUTTONS = 1
);
    logic [10:0]                  ps2_key;
    logic [15:0]                  joystick_0;
    logic [15:0]                  joystick_1;
    logic [4*NPLAYERS-1:0]        out_dir;
    logic [NBUTTONS*NPLAYERS-1:0] out_btn;
    logic [NPLAYERS-1:0]          out_start;
    logic [NPLAYERS-1:0]          out_coin;

    modport master (
        output ps2_key, joystick_0, joystick_1,
        input  out_dir, out_btn, out_start, out_coin
    );

    modport slave (
        input  ps2_key, joystick_0, joystick_1,
        output out_dir, out_btn, out_start, out_coin
    );
endinterface

// File: rtl/coin_pulse.sv
// Turns a rising edge of a coin request into one fixed-length pulse; edges during a pulse are dropped.
module coin_pulse #(
    parameter int CYCLES = 1200000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic trig,
    output logic pulse
);
    localparam int CW = $clog2(CYCLES + 1);

    logic          trig_q, trig_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    // Edge detect and pulse down-counter.
    always_comb begin
        trig_d = trig;
        if (cnt_q != {CW{1'b0}}) begin
            cnt_d = cnt_q - CW'(1);
        end else if (trig && !trig_q) begin
            cnt_d = CW'(CYCLES);
        end else begin
            cnt_d = cnt_q;
        end
        pulse_d = (cnt_d != {CW{1'b0}});
    end

    // State registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            trig_q  <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            pulse_q <= 1'b0;
        end else begin
            trig_q  <= trig_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;
endmodule

// File: rtl/arcade_input_mapper.sv
// Maps PS/2 key events and joystick bits onto per-player direction, button, start and coin outputs.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int NPLAYERS    = 2,
    parameter int NBUTTONS    = 1,
    parameter int COIN_CYCLES = 1200000,
    parameter int AF_DIV      = 400000
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    arcade_input_mapper_if.slave bus,
    input  logic                joy_merge,
    input  logic [1:0]          rotate,
    input  logic [NBUTTONS-1:0] af_en,
    input  logic                coin_on_start
);
    localparam int AFW = (AF_DIV > 1) ? $clog2(AF_DIV) : 1;

    logic                         tog_q, tog_d;
    key_state_t [1:0]             key_q, key_d;
    logic                         ready_q, ready_d;
    logic [AFW-1:0]               af_cnt_q, af_cnt_d;
    logic                         af_phase_q, af_phase_d;
    logic [4*NPLAYERS-1:0]        dir_q, dir_d;
    logic [NBUTTONS*NPLAYERS-1:0] btn_q, btn_d;
    logic [NPLAYERS-1:0]          start_q, start_d;
    logic [NPLAYERS-1:0]          coin_trig_s, coin_out_s;
    key_map_t                     map_s;
    logic [1:0][15:0]             joy_s;
    logic [3:0]                   raw_s, rot_s;
    logic                         btn_req_s, start_req_s, coin_req_s;

    // Key event capture: one update per ps2_key[10] toggle.
    always_comb begin
        map_s = map_key(bus.ps2_key[8], bus.ps2_key[7:0]);
        tog_d = bus.ps2_key[10];
        key_d = key_q;
        if ((bus.ps2_key[10] != tog_q) && map_s.hit) begin
            key_d[map_s.player][map_s.idx] = bus.ps2_key[9];
        end else begin
            key_d = key_q;
        end
    end

    // Autofire phase generator; ready_q holds outputs at zero for the first edge after reset.
    always_comb begin
        ready_d = 1'b1;
        if (af_cnt_q == AFW'(AF_DIV - 1)) begin
            af_cnt_d   = {AFW{1'b0}};
            af_phase_d = ~af_phase_q;
        end else begin
            af_cnt_d   = af_cnt_q + AFW'(1);
            af_phase_d = af_phase_q;
        end
    end

    // Per-player request merge, rotation and autofire gating.
    always_comb begin
        joy_s[0]    = bus.joystick_0 | (joy_merge ? bus.joystick_1 : 16'h0000);
        joy_s[1]    = joy_merge ? 16'h0000 : bus.joystick_1;
        dir_d       = {(4*NPLAYERS){1'b0}};
        btn_d       = {(NBUTTONS*NPLAYERS){1'b0}};
        start_d     = {NPLAYERS{1'b0}};
        coin_trig_s = {NPLAYERS{1'b0}};
        raw_s       = 4'b0000;
        rot_s       = 4'b0000;
        btn_req_s   = 1'b0;
        start_req_s = 1'b0;
        coin_req_s  = 1'b0;
        for (int p = 0; p < NPLAYERS; p++) begin
            raw_s = key_q[p][3:0] | joy_s[p][3:0];
            case (rotate_e'(rotate))
                ROT_CW:   rot_s = {raw_s[1], raw_s[0], raw_s[2], raw_s[3]};
                ROT_FLIP: rot_s = {raw_s[2], raw_s[3], raw_s[0], raw_s[1]};
                ROT_CCW:  rot_s = {raw_s[0], raw_s[1], raw_s[3], raw_s[2]};
                default:  rot_s = raw_s;
            endcase
            dir_d[4*p +: 4] = ready_q ? rot_s : 4'b0000;
            for (int k = 0; k < NBUTTONS; k++) begin
                btn_req_s = key_q[p][KEY_BTN0 + k] | joy_s[p][joy_btn_idx(k)];
                btn_d[p*NBUTTONS + k] = ready_q & btn_req_s & (af_en[k] ? af_phase_q : 1'b1);
            end
            start_req_s    = key_q[p][KEY_START] | joy_s[p][joy_start_idx(NBUTTONS)];
            coin_req_s     = key_q[p][KEY_COIN]  | joy_s[p][joy_coin_idx(NBUTTONS)];
            start_d[p]     = ready_q & start_req_s;
            coin_trig_s[p] = ready_q & (coin_req_s | (coin_on_start & start_req_s));
        end
    end

    // State and output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q      <= 1'b0;
            key_q      <= '{default: {KEY_BITS{1'b0}}};
            ready_q    <= 1'b0;
            af_cnt_q   <= {AFW{1'b0}};
            af_phase_q <= 1'b0;
            dir_q      <= {(4*NPLAYERS){1'b0}};
            btn_q      <= {(NBUTTONS*NPLAYERS){1'b0}};
            start_q    <= {NPLAYERS{1'b0}};
        end else begin
            tog_q      <= tog_d;
            key_q      <= key_d;
            ready_q    <= ready_d;
            af_cnt_q   <= af_cnt_d;
            af_phase_q <= af_phase_d;
            dir_q      <= dir_d;
            btn_q      <= btn_d;
            start_q    <= start_d;
        end
    end

    for (genvar p = 0; p < NPLAYERS; p++) begin : g_coin
        coin_pulse #(.CYCLES(COIN_CYCLES)) u_coin (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .trig    (coin_trig_s[p]),
            .pulse   (coin_out_s[p])
        );
    end

    assign bus.out_dir   = dir_q;
    assign bus.out_btn   = btn_q;
    assign bus.out_start = start_q;
    assign bus.out_coin  = coin_out_s;
endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: two players, two buttons, short coin pulse and autofire period.
module tb_arcade_input_mapper;
    localparam int NP = 2;
    localparam int NB = 2;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          joy_merge;
    logic [1:0]    rotate;
    logic [NB-1:0] af_en;
    logic          coin_on_start;
    logic          tog = 1'b0;
    int            n_cmp = 0;
    int            n_err = 0;

    arcade_input_mapper_if #(.NPLAYERS(NP), .NBUTTONS(NB)) bus ();

    arcade_input_mapper #(
        .NPLAYERS    (NP),
        .NBUTTONS    (NB),
        .COIN_CYCLES (10),
        .AF_DIV      (4)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .bus           (bus),
        .joy_merge     (joy_merge),
        .rotate        (rotate),
        .af_en         (af_en),
        .coin_on_start (coin_on_start)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
        tog = ~tog;
        bus.ps2_key = {tog, pressed, ext, code};
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dir"},   32'(bus.out_dir),   32'h0);
        chk({tag, "_btn"},   32'(bus.out_btn),   32'h0);
        chk({tag, "_start"}, 32'(bus.out_start), 32'h0);
        chk({tag, "_coin"},  32'(bus.out_coin),  32'h0);
    endtask

    initial begin
        reset_n        = 1'b0;
        joy_merge      = 1'b0;
        rotate         = 2'd0;
        af_en          = 2'b00;
        coin_on_start  = 1'b0;
        bus.ps2_key    = 11'h000;
        bus.joystick_0 = 16'h0000;
        bus.joystick_1 = 16'h0000;
        wait_neg(2);
        chk_all_zero("reset");

        // Release with right + button0 held and autofire on button0: phase flips every 4 edges.
        bus.joystick_0 = 16'h0011;
        af_en          = 2'b01;
        reset_n        = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            wait_neg(1);
            chk("af_btn", 32'(bus.out_btn), ((((k - 1) / 4) % 2) == 1) ? 32'h1 : 32'h0);
            chk("rel_dir", 32'(bus.out_dir), (k == 1) ? 32'h0 : 32'h01);
        end
        af_en = 2'b00;
        for (int k = 0; k < 4; k++) begin
            wait_neg(1);
            chk("af_off", 32'(bus.out_btn), 32'h1);
        end
        bus.joystick_0 = 16'h0000;
        wait_neg(1);
        chk("joy_clear", 32'(bus.out_dir), 32'h0);

        // Key events: two-cycle latency, arrows need the extended flag.
        send_key(1'b1, 1'b1, 8'h75);
        wait_neg(1);
        chk("key_lat1", 32'(bus.out_dir), 32'h0);
        wait_neg(1);
        chk("key_up", 32'(bus.out_dir), 32'h08);
        send_key(1'b0, 1'b0, 8'h75);
        wait_neg(2);
        chk("nonext_ignored", 32'(bus.out_dir), 32'h08);
        send_key(1'b0, 1'b1, 8'h75);
        wait_neg(2);
        chk("key_up_rel", 32'(bus.out_dir), 32'h0);
        send_key(1'b1, 1'b0, 8'h2D);
        wait_neg(2);
        chk("p1_up", 32'(bus.out_dir), 32'h80);
        send_key(1'b0, 1'b1, 8'h2D);
        wait_neg(2);
        chk("p1_up_rel", 32'(bus.out_dir), 32'h0);
        send_key(1'b1, 1'b0, 8'h1B);
        wait_neg(2);
        chk("p1_btn1", 32'(bus.out_btn), 32'h8);
        send_key(1'b0, 1'b0, 8'h1B);
        wait_neg(2);
        chk("p1_btn1_rel", 32'(bus.out_btn), 32'h0);

        // Rotation.
        rotate = 2'd1; bus.joystick_0 = 16'h0002;
        wait_neg(1);
        chk("rot_cw_left", 32'(bus.out_dir), 32'h08);
        rotate = 2'd3; bus.joystick_0 = 16'h0004;
        wait_neg(1);
        chk("rot_ccw_down", 32'(bus.out_dir), 32'h01);
        bus.joystick_0 = 16'h0002;
        wait_neg(1);
        chk("rot_ccw_left", 32'(bus.out_dir), 32'h04);
        rotate = 2'd2;
        wait_neg(1);
        chk("rot_flip_left", 32'(bus.out_dir), 32'h01);
        rotate = 2'd1; bus.joystick_0 = 16'h0000; bus.joystick_1 = 16'h0008;
        wait_neg(1);
        chk("rot_cw_p1_up", 32'(bus.out_dir), 32'h10);
        rotate = 2'd0; bus.joystick_1 = 16'h0000;

        // Joystick merge, player-1 start and coin.
        joy_merge = 1'b1; bus.joystick_1 = 16'h0010;
        wait_neg(1);
        chk("merge_btn", 32'(bus.out_btn), 32'h1);
        joy_merge = 1'b0;
        wait_neg(1);
        chk("unmerged_btn", 32'(bus.out_btn), 32'h4);
        bus.joystick_1 = 16'h0040;
        wait_neg(1);
        chk("p1_start", 32'(bus.out_start), 32'h2);
        chk("p1_start_nocoin", 32'(bus.out_coin), 32'h0);
        bus.joystick_1 = 16'h0080;
        wait_neg(1);
        chk("p1_coin", 32'(bus.out_coin), 32'h2);
        bus.joystick_1 = 16'h0000;
        wait_neg(12);
        chk("p1_coin_end", 32'(bus.out_coin), 32'h0);

        // Coin key: 10-cycle pulse, re-press during the pulse is dropped.
        send_key(1'b1, 1'b0, 8'h2E);
        for (int k = 1; k <= 14; k++) begin
            wait_neg(1);
            chk("coin_pulse", 32'(bus.out_coin), (k >= 2 && k <= 11) ? 32'h1 : 32'h0);
            if (k == 2) send_key(1'b0, 1'b0, 8'h2E);
            if (k == 4) send_key(1'b1, 1'b0, 8'h2E);
        end
        send_key(1'b0, 1'b0, 8'h2E);
        wait_neg(2);

        // Start also requests coin; then reset mid-pulse with a key held.
        coin_on_start = 1'b1; bus.joystick_0 = 16'h0040;
        wait_neg(1);
        chk("cos_coin", 32'(bus.out_coin), 32'h1);
        chk("cos_start", 32'(bus.out_start), 32'h1);
        bus.joystick_0 = 16'h0000;
        send_key(1'b1, 1'b0, 8'h14);
        wait_neg(2);
        chk("held_btn", 32'(bus.out_btn), 32'h1);
        chk("held_coin", 32'(bus.out_coin), 32'h1);
        reset_n = 1'b0;
        #1;
        bus.ps2_key = 11'h000;
        tog = 1'b0;
        chk_all_zero("mid_reset");
        wait_neg(2);
        reset_n = 1'b1;
        coin_on_start = 1'b0;
        wait_neg(5);
        chk_all_zero("post_reset");
        send_key(1'b1, 1'b0, 8'h14);
        wait_neg(2);
        chk("new_key_btn", 32'(bus.out_btn), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
